// File: rtl/rover_sensor_pkg.sv
// Shared constants and helpers for the rover sensor front end.
package rover_sensor_pkg;

   localparam int DEFAULT_CHANNELS        = 4;
   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

   // Width of a counter that must hold 0..cycles.
   function automatic int counter_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/sensor_channel_filter.sv
// One sensor channel: synchroniser, polarity normalisation, stable-time
// debounce filter and registered rise/fall pulses.
module sensor_channel_filter
   import rover_sensor_pkg::*;
#(
   parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic INVERT          = 1'b1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sensor,
   output logic rebuilt,
   output logic rise_pulse,
   output logic fall_pulse
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sensor_channel_filter: SYNC_STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("sensor_channel_filter: DEBOUNCE_CYCLES must be >= 1");
   end

   localparam int            CW   = counter_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          count_q, count_d;
   logic                   rebuilt_d, rise_d, fall_d;
   logic                   level;

   // Idle raw level is preloaded so the normalised level starts inactive.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours; blocking here would
   // collapse the synchroniser into a single stage.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{INVERT}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sensor};
      end
   end

   assign level = sync_q[SYNC_STAGES-1] ^ INVERT;

   // NOTE: every output of this block gets a default first so no path
   // leaves a variable unassigned, which would infer a latch.
   always_comb begin
      count_d   = count_q;
      rebuilt_d = rebuilt;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      if (level == rebuilt) begin
         count_d = '0;
      end else if (count_q == LAST) begin
         count_d   = '0;
         rebuilt_d = level;
         rise_d    = level;
         fall_d    = ~level;
      end else begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= '0;
         rebuilt    <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         count_q    <= count_d;
         rebuilt    <= rebuilt_d;
         rise_pulse <= rise_d;
         fall_pulse <= fall_d;
      end
   end

endmodule

// File: rtl/sensor_debounce_sync.sv
// Multi-channel sensor front end: per-channel filters plus sticky event
// flags and a combined activity indicator.
module sensor_debounce_sync
   import rover_sensor_pkg::*;
#(
   parameter int                  CHANNELS        = DEFAULT_CHANNELS,
   parameter int                  SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int                  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [CHANNELS-1:0] INVERT_MASK     = {CHANNELS{1'b1}}
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] sensors,
   input  logic [CHANNELS-1:0] clear_events,
   output logic [CHANNELS-1:0] rebuilt_signal,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic [CHANNELS-1:0] event_flags,
   output logic                any_active
);

   if (CHANNELS < 1) begin : g_bad_channels
      $error("sensor_debounce_sync: CHANNELS must be >= 1");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      sensor_channel_filter #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INVERT          (INVERT_MASK[i])
      ) u_filter (
         .clock      (clock),
         .reset_n    (reset_n),
         .sensor     (sensors[i]),
         .rebuilt    (rebuilt_signal[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i])
      );
   end

   // A rise in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         event_flags <= '0;
      end else begin
         event_flags <= (event_flags & ~clear_events) | rise_pulse;
      end
   end

   assign any_active = |rebuilt_signal;

endmodule

// File: tb/tb_sensor_debounce_sync.sv
// Directed bench for sensor_debounce_sync: default 4-channel instance plus
// an 8-channel, 3-stage, transparent-filter instance.
module tb_sensor_debounce_sync;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [3:0] sensors, clear_events;
   logic [3:0] rebuilt_signal, rise_pulse, fall_pulse, event_flags;
   logic       any_active;

   logic [7:0] s8_sensors, s8_clear;
   logic [7:0] s8_rebuilt, s8_rise, s8_fall, s8_flags;
   logic       s8_any;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   sensor_debounce_sync dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .sensors        (sensors),
      .clear_events   (clear_events),
      .rebuilt_signal (rebuilt_signal),
      .rise_pulse     (rise_pulse),
      .fall_pulse     (fall_pulse),
      .event_flags    (event_flags),
      .any_active     (any_active)
   );

   sensor_debounce_sync #(
      .CHANNELS        (8),
      .SYNC_STAGES     (3),
      .DEBOUNCE_CYCLES (1),
      .INVERT_MASK     (8'h0F)
   ) dut8 (
      .clock          (clock),
      .reset_n        (reset_n),
      .sensors        (s8_sensors),
      .clear_events   (s8_clear),
      .rebuilt_signal (s8_rebuilt),
      .rise_pulse     (s8_rise),
      .fall_pulse     (s8_fall),
      .event_flags    (s8_flags),
      .any_active     (s8_any)
   );

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [16:0] acc;
      logic [32:0] acc8;
      reset_n = 1'b0; sensors = 4'hF; clear_events = 4'h0;
      s8_sensors = 8'h0F; s8_clear = 8'h00;
      #1;
      if ({rebuilt_signal, rise_pulse, fall_pulse, event_flags, any_active} !== 17'b0)
         $display("FAIL reset_outputs: got %h expected 0",
                  {rebuilt_signal, rise_pulse, fall_pulse, event_flags, any_active});
      else passed++;
      total++;
      tick(3);
      reset_n = 1'b1;
      acc = '0; acc8 = '0;
      repeat (100) begin
         tick(1);
         acc  |= {rebuilt_signal, rise_pulse, fall_pulse, event_flags, any_active};
         acc8 |= {s8_rebuilt, s8_rise, s8_fall, s8_flags, s8_any};
      end
      if (acc !== 17'b0) $display("FAIL idle_100: got %h expected 0", acc);
      else passed++;
      total++;
      if (acc8 !== 33'b0) $display("FAIL idle8_100: got %h expected 0", acc8);
      else passed++;
      total++;
   endtask

   task automatic test_single_rise();
      sensors[2] = 1'b0;
      tick(17);
      if (rebuilt_signal !== 4'b0000 || rise_pulse !== 4'b0000)
         $display("FAIL rise_early: rebuilt %b rise %b expected 0000 0000", rebuilt_signal, rise_pulse);
      else passed++;
      total++;
      tick(1);
      if (rebuilt_signal !== 4'b0100 || rise_pulse !== 4'b0100 || any_active !== 1'b1 || event_flags !== 4'b0000)
         $display("FAIL rise_edge17: rebuilt %b rise %b any %b flags %b expected 0100 0100 1 0000",
                  rebuilt_signal, rise_pulse, any_active, event_flags);
      else passed++;
      total++;
      tick(1);
      if (rise_pulse !== 4'b0000 || event_flags !== 4'b0100)
         $display("FAIL rise_after: rise %b flags %b expected 0000 0100", rise_pulse, event_flags);
      else passed++;
      total++;
      sensors[2] = 1'b1;
      tick(17);
      if (rebuilt_signal !== 4'b0100 || fall_pulse !== 4'b0000)
         $display("FAIL fall_early: rebuilt %b fall %b expected 0100 0000", rebuilt_signal, fall_pulse);
      else passed++;
      total++;
      tick(1);
      if (rebuilt_signal !== 4'b0000 || fall_pulse !== 4'b0100 || any_active !== 1'b0 || event_flags !== 4'b0100)
         $display("FAIL fall_edge17: rebuilt %b fall %b any %b flags %b expected 0000 0100 0 0100",
                  rebuilt_signal, fall_pulse, any_active, event_flags);
      else passed++;
      total++;
      tick(1);
      if (fall_pulse !== 4'b0000)
         $display("FAIL fall_width: fall %b expected 0000", fall_pulse);
      else passed++;
      total++;
      clear_events = 4'b0100;
      tick(1);
      clear_events = 4'b0000;
      if (event_flags !== 4'b0000)
         $display("FAIL flag_clear: flags %b expected 0000", event_flags);
      else passed++;
      total++;
   endtask

   task automatic test_glitch();
      logic [12:0] acc;
      sensors[0] = 1'b0;
      tick(15);
      sensors[0] = 1'b1;
      acc = '0;
      repeat (40) begin
         tick(1);
         acc |= {rebuilt_signal, rise_pulse, fall_pulse, any_active};
      end
      if (acc !== 13'b0 || event_flags !== 4'b0000)
         $display("FAIL glitch15: activity %h flags %b expected 0 0000", acc, event_flags);
      else passed++;
      total++;
      sensors[0] = 1'b0;
      tick(16);
      sensors[0] = 1'b1;
      tick(1);
      if (rebuilt_signal !== 4'b0000)
         $display("FAIL hold16_early: rebuilt %b expected 0000", rebuilt_signal);
      else passed++;
      total++;
      tick(1);
      if (rebuilt_signal !== 4'b0001 || rise_pulse !== 4'b0001)
         $display("FAIL hold16_rise: rebuilt %b rise %b expected 0001 0001", rebuilt_signal, rise_pulse);
      else passed++;
      total++;
      tick(15);
      if (rebuilt_signal !== 4'b0001 || fall_pulse !== 4'b0000)
         $display("FAIL hold16_hold: rebuilt %b fall %b expected 0001 0000", rebuilt_signal, fall_pulse);
      else passed++;
      total++;
      tick(1);
      if (rebuilt_signal !== 4'b0000 || fall_pulse !== 4'b0001)
         $display("FAIL hold16_fall: rebuilt %b fall %b expected 0000 0001", rebuilt_signal, fall_pulse);
      else passed++;
      total++;
      clear_events = 4'b0001;
      tick(1);
      clear_events = 4'b0000;
   endtask

   task automatic test_back_to_back();
      sensors[1] = 1'b0; sensors[3] = 1'b0;
      tick(18);
      if (rebuilt_signal !== 4'b1010 || rise_pulse !== 4'b1010 || event_flags !== 4'b0000)
         $display("FAIL dual_rise: rebuilt %b rise %b flags %b expected 1010 1010 0000",
                  rebuilt_signal, rise_pulse, event_flags);
      else passed++;
      total++;
      clear_events = 4'b0010;
      tick(1);
      clear_events = 4'b0000;
      if (event_flags !== 4'b1010)
         $display("FAIL set_wins: flags %b expected 1010", event_flags);
      else passed++;
      total++;
      tick(1);
      if (event_flags !== 4'b1010)
         $display("FAIL flag_sticky: flags %b expected 1010", event_flags);
      else passed++;
      total++;
      clear_events = 4'b1010;
      tick(1);
      clear_events = 4'b0000;
      if (event_flags !== 4'b0000)
         $display("FAIL dual_clear: flags %b expected 0000", event_flags);
      else passed++;
      total++;
      sensors = 4'hF;
      tick(20);
      if (rebuilt_signal !== 4'b0000)
         $display("FAIL dual_release: rebuilt %b expected 0000", rebuilt_signal);
      else passed++;
      total++;
   endtask

   task automatic test_reset_mid();
      sensors[2] = 1'b0;
      tick(20);
      if (rebuilt_signal !== 4'b0100 || event_flags !== 4'b0100)
         $display("FAIL pre_reset: rebuilt %b flags %b expected 0100 0100", rebuilt_signal, event_flags);
      else passed++;
      total++;
      sensors[0] = 1'b0;
      tick(12);
      reset_n = 1'b0;
      #1;
      if ({rebuilt_signal, rise_pulse, fall_pulse, event_flags, any_active} !== 17'b0)
         $display("FAIL async_reset: got %h expected 0",
                  {rebuilt_signal, rise_pulse, fall_pulse, event_flags, any_active});
      else passed++;
      total++;
      tick(3);
      reset_n = 1'b1;
      tick(17);
      if (rebuilt_signal !== 4'b0000 || rise_pulse !== 4'b0000)
         $display("FAIL redetect_early: rebuilt %b rise %b expected 0000 0000", rebuilt_signal, rise_pulse);
      else passed++;
      total++;
      tick(1);
      if (rebuilt_signal !== 4'b0101 || rise_pulse !== 4'b0101)
         $display("FAIL redetect: rebuilt %b rise %b expected 0101 0101", rebuilt_signal, rise_pulse);
      else passed++;
      total++;
      sensors = 4'hF;
      tick(20);
   endtask

   task automatic test_transparent();
      s8_sensors[7] = 1'b1;
      tick(3);
      if (s8_rebuilt !== 8'h00 || s8_rise !== 8'h00)
         $display("FAIL d1_early: rebuilt %h rise %h expected 00 00", s8_rebuilt, s8_rise);
      else passed++;
      total++;
      tick(1);
      if (s8_rebuilt !== 8'h80 || s8_rise !== 8'h80 || s8_any !== 1'b1)
         $display("FAIL d1_rise: rebuilt %h rise %h any %b expected 80 80 1", s8_rebuilt, s8_rise, s8_any);
      else passed++;
      total++;
      tick(1);
      if (s8_rise !== 8'h00 || s8_flags !== 8'h80 || s8_rebuilt !== 8'h80)
         $display("FAIL d1_width: rise %h flags %h rebuilt %h expected 00 80 80", s8_rise, s8_flags, s8_rebuilt);
      else passed++;
      total++;
      s8_sensors[7] = 1'b0;
      s8_sensors[0] = 1'b0;
      s8_sensors[4] = 1'b1;
      tick(4);
      if (s8_rebuilt !== 8'h11 || s8_rise !== 8'h11 || s8_fall !== 8'h80)
         $display("FAIL d1_multi: rebuilt %h rise %h fall %h expected 11 11 80", s8_rebuilt, s8_rise, s8_fall);
      else passed++;
      total++;
      tick(1);
      if (s8_rise !== 8'h00 || s8_fall !== 8'h00 || s8_flags !== 8'h91)
         $display("FAIL d1_after: rise %h fall %h flags %h expected 00 00 91", s8_rise, s8_fall, s8_flags);
      else passed++;
      total++;
   endtask

   initial begin
      test_reset();
      test_single_rise();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      test_transparent();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
